// File: rtl/and16_serial.sv
// and16_serial: bit-serial bitwise logic unit (AND/NAND/OR/XOR).
// The operands are taken in parallel over a valid/ready handshake. One bit is
// evaluated per clock, LSB first, through a single Nand-built slice. The
// parallel result is returned over a second valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for an operand pair; in_ready high
// SHIFT | WIDTH cycles, one result bit per cycle, LSB first
// DONE  | result held on out with out_valid high until out_ready
module and16_serial #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] out_r;
  logic [1:0]       op_r;
  logic [CNT_W-1:0] cnt;

  function automatic logic nand2(input logic x, input logic y);
    return ~(x & y);
  endfunction

  // Bit slice: every function is composed only of 2-input Nand gates.
  logic a0, b0;
  logic n_ab, n_a, n_b;
  logic f_and, f_nand, f_or, f_xor;
  logic r_bit;

  assign a0     = sa[0];
  assign b0     = sb[0];
  assign n_ab   = nand2(a0, b0);
  assign n_a    = nand2(a0, a0);
  assign n_b    = nand2(b0, b0);
  assign f_nand = n_ab;
  assign f_and  = nand2(n_ab, n_ab);
  assign f_or   = nand2(n_a, n_b);
  assign f_xor  = nand2(nand2(a0, n_ab), nand2(b0, n_ab));

  // Select the slice output for the op latched at accept time.
  always_comb begin
    r_bit = f_xor;
    case (op_r)
      OP_AND:  r_bit = f_and;
      OP_NAND: r_bit = f_nand;
      OP_OR:   r_bit = f_or;
      default: r_bit = f_xor;
    endcase
  end

  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  assign res_next = {r_bit, res[WIDTH-1:1]};
  assign last_bit = (cnt == CNT_LAST);

  // Sequencer: accept, shift WIDTH bits, then hold the result until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      out_r <= '0;
      op_r  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sa    <= in_a;
            sb    <= in_b;
            op_r  <= op;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          res <= res_next;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          if (last_bit) begin
            // Result word is complete with this edge's bit; present it directly.
            out_r <= res_next;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign out       = out_r;

endmodule

// File: tb/tb_and16_serial.sv
// Self-checking bench for and16_serial: cycle-stamped behavioural model plus
// directed cases and a randomized run with random back-pressure.
module tb_and16_serial;
  localparam int WIDTH = 16;
  localparam int CNT_W = 5;
  localparam int PER   = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  wire         in_ready;
  wire         out_valid;
  wire         busy;
  wire  [15:0] out;

  and16_serial #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .busy(busy)
  );

  always #(PER/2) clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o);
    case (o)
      2'b00:   return a & b;
      2'b01:   return ~(a & b);
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Model: an op accepted on cycle c has its result visible after cycle c+WIDTH
  // and is retired on the first later cycle with out_ready high.
  int          cyc = 0;
  bit          m_pending = 0;
  int          m_done_at = 0;
  logic [15:0] m_res = '0;
  logic [15:0] m_out = '0;
  int          m_del = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc       <= 0;
      m_pending <= 0;
      m_out     <= '0;
    end else begin
      cyc <= cyc + 1;
      if (m_pending) begin
        if (cyc + 1 == m_done_at) m_out <= m_res;
        else if (cyc + 1 > m_done_at && out_ready) begin
          m_pending <= 0;
          m_del     <= m_del + 1;
        end
      end else if (in_valid) begin
        m_pending <= 1;
        m_done_at <= cyc + 1 + WIDTH;
        m_res     <= ref_op(in_a, in_b, op);
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, !m_pending});
    chk("busy", {31'd0, busy}, {31'd0, m_pending});
    chk("out_valid", {31'd0, out_valid}, {31'd0, (m_pending && cyc >= m_done_at)});
    chk("out", {16'd0, out}, {16'd0, m_out});
  end

  // Log of results actually handed over by the DUT.
  int          n_got = 0;
  logic [15:0] got_log[$];

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_got <= n_got + 1;
      got_log.push_back(out);
    end
  end

  bit rand_or = 0;
  always @(negedge clk) begin
    if (rand_or) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic feed(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o, output time t_acc);
    bit done_f;
    done_f = 0;
    t_acc = 0;
    in_a = a; in_b = b; op = o; in_valid = 1'b1;
    for (int k = 0; k < 400 && !done_f; k++) begin
      if (in_ready) begin
        @(posedge clk);
        t_acc = $time;
        #1;
        in_valid = 1'b0;
        done_f = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done_f) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #(PER * 90000);
    $display("FAIL global_timeout: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    time t1, t2, t3;
    int  lat;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out", {16'd0, out}, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // 1: AND, latency and single-cycle valid pulse
    out_ready = 1'b1;
    feed(16'hFFFF, 16'h00FF, 2'b00, t1);
    wait_valid(lat);
    chk("t1_latency", lat, 32'd16);
    chk("t1_out", {16'd0, out}, 32'h00FF);
    @(posedge clk); #1;
    chk("t1_pulse", {31'd0, out_valid}, 32'd0);
    chk("t1_out_kept", {16'd0, out}, 32'h00FF);

    // 2: NAND/OR/XOR back to back, 18-cycle accept spacing
    got_log.delete();
    feed(16'hF0F0, 16'hFF00, 2'b01, t1);
    feed(16'hF0F0, 16'hFF00, 2'b10, t2);
    feed(16'hF0F0, 16'hFF00, 2'b11, t3);
    chk("t2_spacing_a", 32'((t2 - t1) / PER), 32'd18);
    chk("t2_spacing_b", 32'((t3 - t2) / PER), 32'd18);
    wait_valid(lat);
    @(posedge clk); #1;
    chk("t2_count", got_log.size(), 32'd3);
    chk("t2_nand", {16'd0, got_log[0]}, 32'h0FFF);
    chk("t2_or", {16'd0, got_log[1]}, 32'hFFF0);
    chk("t2_xor", {16'd0, got_log[2]}, 32'h0FF0);

    // 3: back-pressure holds the result
    out_ready = 1'b0;
    feed(16'h1234, 16'hFFFF, 2'b00, t1);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_out", {16'd0, out}, 32'h1234);
      chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_release", {31'd0, out_valid}, 32'd0);

    // 4: in_valid held with new operands during SHIFT
    got_log.delete();
    feed(16'h5555, 16'hFFFF, 2'b00, t1);
    feed(16'hAAAA, 16'h0F0F, 2'b00, t2);
    chk("t4_second_accept", 32'((t2 - t1) / PER), 32'd18);
    wait_valid(lat);
    @(posedge clk); #1;
    chk("t4_count", got_log.size(), 32'd2);
    chk("t4_first", {16'd0, got_log[0]}, 32'h5555);
    chk("t4_second", {16'd0, got_log[1]}, 32'h0A0A);

    // 5: reset during SHIFT aborts the op
    got_log.delete();
    feed(16'hFFFF, 16'h1234, 2'b10, t1);
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_out", {16'd0, out}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    feed(16'h8001, 16'h8001, 2'b00, t1);
    wait_valid(lat);
    chk("t5_result", {16'd0, out}, 32'h8001);
    @(posedge clk); #1;
    chk("t5_count", got_log.size(), 32'd1);

    // 6: random operands/ops with random back-pressure
    rand_or = 1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      feed(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), t1);
    end
    @(negedge clk);
    rand_or = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && m_pending; k++) @(negedge clk);
    chk("t6_drained", {31'd0, m_pending}, 32'd0);
    @(negedge clk);
    chk("t6_delivered", n_got, m_del);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
